child_input_filter: RTL

Upstream conditioning stage for the `child` logic block. It synchronises three asynchronous raw inputs into the `clk` domain and debounces each one independently. It then drives clean, glitch-free `a`, `b`, `c` into `child`. A one-cycle `changed` strobe and a `stable` flag let downstream logic know when the filtered vector has moved and when it is settled.

---
 rtl/child_input_filter.sv | 76 +++++++
 1 files changed

// File: rtl/child_input_filter.sv
// Input conditioning for the child block: three raw inputs are
// synchronised, debounced and presented as clean a/b/c levels.
module child_input_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 16,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic raw_a,
  input  logic raw_b,
  input  logic raw_c,
  output logic a,
  output logic b,
  output logic c,
  output logic changed,
  output logic stable
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);

  logic [2:0][SYNC_STAGES-1:0] sync;
  logic [2:0][CNT_W-1:0]       cnt;
  logic [2:0][CNT_W-1:0]       cnt_nxt;
  logic [2:0]                  q;
  logic [2:0]                  q_nxt;
  logic [2:0]                  flip;
  logic [2:0]                  s;
  logic [2:0]                  raw;

  assign raw = {raw_c, raw_b, raw_a};

  // Per-channel comparator and debounce counter next state.
  always_comb begin
    cnt_nxt = '0;
    q_nxt   = q;
    flip    = '0;
    s       = '0;
    for (int i = 0; i < 3; i++) begin
      s[i] = sync[i][SYNC_STAGES-1];
      if (enable && (s[i] != q[i])) begin
        if (cnt[i] == LAST) begin
          q_nxt[i] = s[i];
          flip[i]  = 1'b1;
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Synchronisers always shift; state and status flags are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt     <= '0;
      q       <= '0;
      changed <= 1'b0;
      stable  <= 1'b1;
    end else begin
      for (int i = 0; i < 3; i++) begin
        sync[i] <= {sync[i][SYNC_STAGES-2:0], raw[i]};
      end
      cnt     <= cnt_nxt;
      q       <= q_nxt;
      changed <= |flip;
      stable  <= (cnt_nxt == '0);
    end
  end

  assign a = q[0];
  assign b = q[1];
  assign c = q[2];

endmodule
